// File: rtl/ahb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_pkg
//   Shared AHB definitions: HTRANS encodings and the state type of the bus
//   default slave that lives in the data-phase response stage.
// -----------------------------------------------------------------------------
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Default-slave data-phase state.
    //   DS_IDLE : no error in progress, the selected slave (or nothing) drives
    //   DS_ERR1 : first ERROR cycle, HREADY low
    //   DS_ERR2 : second ERROR cycle, HREADY high
    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } defslv_state_t;

endpackage : ahb_pkg

// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg
//   Platform-wide configuration shared by the hart and its bus fabric.
//   XLEN is the hart data width and sets every AHB data bus width.
// -----------------------------------------------------------------------------
package config_pkg;

    localparam int XLEN = 64;

endpackage : config_pkg

// File: rtl/ahb_onehot_mux.sv
// -----------------------------------------------------------------------------
// ahb_onehot_mux
//   AND-OR one-hot selector for the AHB data-phase return path. Each slave's
//   read data, ready and response are gated by its select bit and OR-ed
//   together. With an all-zero select every output is 0.
//
// Ports
//   sel        in   NSLAVES        one-hot data-phase select (or all zero)
//   data_vec   in   NSLAVES*XLEN   per-slave read data, slave i at [i*XLEN +: XLEN]
//   ready_vec  in   NSLAVES        per-slave HREADYOUT
//   resp_vec   in   NSLAVES        per-slave HRESP
//   data       out  XLEN           selected read data
//   ready      out  1              selected ready (0 when nothing selected)
//   resp       out  1              selected response (0 when nothing selected)
// -----------------------------------------------------------------------------
module ahb_onehot_mux #(
    parameter int NSLAVES = 8,
    parameter int XLEN    = 64
) (
    input  logic [NSLAVES-1:0]      sel,
    input  logic [NSLAVES*XLEN-1:0] data_vec,
    input  logic [NSLAVES-1:0]      ready_vec,
    input  logic [NSLAVES-1:0]      resp_vec,
    output logic [XLEN-1:0]         data,
    output logic                    ready,
    output logic                    resp
);

    // Each slave's data forced to zero unless that slave is selected.
    logic [XLEN-1:0] masked_data [NSLAVES];

    genvar gi;
    generate
        for (gi = 0; gi < NSLAVES; gi++) begin : g_mask
            assign masked_data[gi] = data_vec[gi*XLEN +: XLEN] & {XLEN{sel[gi]}};
        end
    endgenerate

    always_comb begin
        data = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            data = data | masked_data[i];
        end
    end

    assign ready = |(sel & ready_vec);
    assign resp  = |(sel & resp_vec);

endmodule : ahb_onehot_mux

// File: rtl/ahb_resp_mux.sv
// -----------------------------------------------------------------------------
// ahb_resp_mux
//   Data-phase response stage between the AHB slaves and the hart's master.
//   Registers the address-phase slave select and steers the selected slave's
//   read data, ready and response back to the master. Also implements the
//   bus default slave: a transfer that decodes to no slave or to several
//   slaves receives the two-cycle AHB ERROR response and bumps a saturating
//   error counter.
//
// Ports
//   HCLK        in   1              bus clock
//   HRESETn     in   1              asynchronous active-low reset
//   HSELVec     in   NSLAVES        address-phase selects from the decoder
//   HTRANS      in   2              master transfer type
//   HREADDATAV  in   NSLAVES*XLEN   per-slave read data, slave i at [i*XLEN +: XLEN]
//   HREADYVec   in   NSLAVES        per-slave HREADYOUT
//   HRESPVec    in   NSLAVES        per-slave HRESP
//   HREADY      out  1              bus ready, also fed back to the slaves
//   HRESP       out  1              bus response, 0 = OKAY, 1 = ERROR
//   HREADDATA   out  XLEN           bus read data
//   HSELDVec    out  NSLAVES        registered data-phase select
//   ErrCount    out  ERRBITS        saturating count of default-slave errors
// -----------------------------------------------------------------------------
module ahb_resp_mux
    import config_pkg::*;
    import ahb_pkg::*;
#(
    parameter int NSLAVES = 8,
    parameter int ERRBITS = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [NSLAVES-1:0]      HSELVec,
    input  logic [1:0]              HTRANS,
    input  logic [NSLAVES*XLEN-1:0] HREADDATAV,
    input  logic [NSLAVES-1:0]      HREADYVec,
    input  logic [NSLAVES-1:0]      HRESPVec,
    output logic                    HREADY,
    output logic                    HRESP,
    output logic [XLEN-1:0]         HREADDATA,
    output logic [NSLAVES-1:0]      HSELDVec,
    output logic [ERRBITS-1:0]      ErrCount
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NSLAVES-1:0] hseld_reg;
    logic [NSLAVES-1:0] hseld_next;
    defslv_state_t      state_reg;
    defslv_state_t      state_next;
    logic [ERRBITS-1:0] err_count_reg;
    logic [ERRBITS-1:0] err_count_next;

    // -------------------------------------------------------------------------
    // Selected-slave return path
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] mux_data;
    logic            mux_ready;
    logic            mux_resp;

    ahb_onehot_mux #(
        .NSLAVES (NSLAVES),
        .XLEN    (XLEN)
    ) u_mux (
        .sel       (hseld_reg),
        .data_vec  (HREADDATAV),
        .ready_vec (HREADYVec),
        .resp_vec  (HRESPVec),
        .data      (mux_data),
        .ready     (mux_ready),
        .resp      (mux_resp)
    );

    // -------------------------------------------------------------------------
    // Data-phase outputs. The error states override the slave path; with no
    // slave selected the bus answers a zero-wait OKAY with zero data.
    // -------------------------------------------------------------------------
    logic            bus_ready;
    logic            bus_resp;
    logic [XLEN-1:0] bus_data;

    always_comb begin
        bus_ready = 1'b1;
        bus_resp  = 1'b0;
        bus_data  = '0;
        unique case (state_reg)
            DS_ERR1: begin
                bus_ready = 1'b0;
                bus_resp  = 1'b1;
            end
            DS_ERR2: begin
                bus_ready = 1'b1;
                bus_resp  = 1'b1;
            end
            default: begin
                bus_ready = (|hseld_reg) ? mux_ready : 1'b1;
                bus_resp  = mux_resp;
                bus_data  = mux_data;
            end
        endcase
    end

    assign HREADY    = bus_ready;
    assign HRESP     = bus_resp;
    assign HREADDATA = bus_data;
    assign HSELDVec  = hseld_reg;
    assign ErrCount  = err_count_reg;

    // -------------------------------------------------------------------------
    // Address-phase acceptance and decode check
    // -------------------------------------------------------------------------
    logic accept;
    logic sel_onehot;
    logic bad_decode;

    always_comb begin
        accept     = bus_ready && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
        sel_onehot = $onehot(HSELVec);
        bad_decode = accept && !sel_onehot;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // While HREADY is low (slave wait state or ERR1) the select holds.
        hseld_next = hseld_reg;
        if (bus_ready) begin
            hseld_next = (accept && sel_onehot) ? HSELVec : '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            DS_IDLE: state_next = bad_decode ? DS_ERR1 : DS_IDLE;
            DS_ERR1: state_next = DS_ERR2;
            // HREADY is high in ERR2, so a new address phase is sampled here
            // and a second bad decode chains straight back into ERR1.
            DS_ERR2: state_next = bad_decode ? DS_ERR1 : DS_IDLE;
            default: state_next = DS_IDLE;
        endcase
    end

    // bad_decode can only fire in IDLE or ERR2 (ERR1 holds HREADY low), so it
    // marks exactly the transitions into ERR1.
    always_comb begin
        err_count_next = err_count_reg;
        if (bad_decode && (err_count_reg != {ERRBITS{1'b1}})) begin
            err_count_next = err_count_reg + {{(ERRBITS-1){1'b0}}, 1'b1};
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hseld_reg     <= '0;
            state_reg     <= DS_IDLE;
            err_count_reg <= '0;
        end else begin
            hseld_reg     <= hseld_next;
            state_reg     <= state_next;
            err_count_reg <= err_count_next;
        end
    end

endmodule : ahb_resp_mux

// File: tb/tb_ahb_resp_mux.sv
// -----------------------------------------------------------------------------
// tb_ahb_resp_mux
//   Directed bench for ahb_resp_mux. Inputs change on the falling clock edge
//   and outputs are sampled 1 ns later, well clear of the rising edge.
// -----------------------------------------------------------------------------
module tb_ahb_resp_mux;
    import ahb_pkg::*;

    localparam int NS = 8;
    localparam int XL = 64;
    localparam int EB = 16;

    localparam logic [XL-1:0] ROM_WORD = 64'hDEADBEEF_00000013;
    localparam logic [XL-1:0] S1_WORD  = 64'hC0DE0000_00000001;
    localparam logic [XL-1:0] S2_WORD  = 64'hC0DE0000_00000002;
    localparam logic [XL-1:0] S3_WORD  = 64'hC0DE0000_00000003;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic [NS-1:0]    HSELVec;
    logic [1:0]       HTRANS;
    logic [NS*XL-1:0] HREADDATAV;
    logic [NS-1:0]    HREADYVec;
    logic [NS-1:0]    HRESPVec;
    logic             HREADY;
    logic             HRESP;
    logic [XL-1:0]    HREADDATA;
    logic [NS-1:0]    HSELDVec;
    logic [EB-1:0]    ErrCount;

    int vectors     = 0;
    int miscompares = 0;

    always #5 HCLK = ~HCLK;

    ahb_resp_mux #(
        .NSLAVES (NS),
        .ERRBITS (EB)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSELVec    (HSELVec),
        .HTRANS     (HTRANS),
        .HREADDATAV (HREADDATAV),
        .HREADYVec  (HREADYVec),
        .HRESPVec   (HRESPVec),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .HREADDATA  (HREADDATA),
        .HSELDVec   (HSELDVec),
        .ErrCount   (ErrCount)
    );

    // -------------------------------------------------------------------------
    task automatic test_reset();
        HRESETn    = 1'b0;
        HTRANS     = HTRANS_NONSEQ;
        HSELVec    = 8'h01;
        HREADYVec  = 8'hFF;
        HRESPVec   = 8'h00;
        HREADDATAV = '0;
        HREADDATAV[0*XL +: XL] = ROM_WORD;
        HREADDATAV[1*XL +: XL] = S1_WORD;
        HREADDATAV[2*XL +: XL] = S2_WORD;
        HREADDATAV[3*XL +: XL] = S3_WORD;
        for (int c = 0; c < 4; c++) begin
            @(negedge HCLK); #1;
            vectors++;
            if ({HREADY, HRESP, HREADDATA, ErrCount} !== {1'b1, 1'b0, 64'h0, 16'h0}) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: got ready=%0b resp=%0b data=%h err=%h, expected ready=1 resp=0 data=0 err=0",
                         c, HREADY, HRESP, HREADDATA, ErrCount);
            end
        end
        @(negedge HCLK);
        HTRANS  = HTRANS_IDLE;
        HSELVec = 8'h00;
        HRESETn = 1'b1;
        $display("test_reset done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_rom_read();
        @(negedge HCLK);
        HTRANS  = HTRANS_NONSEQ;
        HSELVec = 8'h01;
        @(negedge HCLK);
        HTRANS  = HTRANS_IDLE;
        HSELVec = 8'h00;
        #1;
        vectors++;
        if ({HREADY, HRESP, HREADDATA, HSELDVec} !== {1'b1, 1'b0, ROM_WORD, 8'h01}) begin
            miscompares++;
            $display("FAIL rom_read: got ready=%0b resp=%0b data=%h seld=%h, expected ready=1 resp=0 data=%h seld=01",
                     HREADY, HRESP, HREADDATA, HSELDVec, ROM_WORD);
        end
        @(negedge HCLK); #1;
        vectors++;
        if ({HREADY, HRESP, HREADDATA, HSELDVec} !== {1'b1, 1'b0, 64'h0, 8'h00}) begin
            miscompares++;
            $display("FAIL idle_after_read: got ready=%0b resp=%0b data=%h seld=%h, expected ready=1 resp=0 data=0 seld=00",
                     HREADY, HRESP, HREADDATA, HSELDVec);
        end
        $display("test_rom_read done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_bad_decode(input logic [NS-1:0] pat, input logic [EB-1:0] exp_cnt);
        @(negedge HCLK);
        HTRANS  = HTRANS_NONSEQ;
        HSELVec = pat;
        @(negedge HCLK);
        HTRANS  = HTRANS_IDLE;
        HSELVec = 8'h00;
        #1;
        vectors++;
        if ({HREADY, HRESP, HREADDATA, ErrCount} !== {1'b0, 1'b1, 64'h0, exp_cnt}) begin
            miscompares++;
            $display("FAIL bad_decode_err1 sel=%h: got ready=%0b resp=%0b data=%h err=%h, expected ready=0 resp=1 data=0 err=%h",
                     pat, HREADY, HRESP, HREADDATA, ErrCount, exp_cnt);
        end
        @(negedge HCLK); #1;
        vectors++;
        if ({HREADY, HRESP, HREADDATA} !== {1'b1, 1'b1, 64'h0}) begin
            miscompares++;
            $display("FAIL bad_decode_err2 sel=%h: got ready=%0b resp=%0b data=%h, expected ready=1 resp=1 data=0",
                     pat, HREADY, HRESP, HREADDATA);
        end
        @(negedge HCLK); #1;
        vectors++;
        if ({HREADY, HRESP, ErrCount} !== {1'b1, 1'b0, exp_cnt}) begin
            miscompares++;
            $display("FAIL bad_decode_done sel=%h: got ready=%0b resp=%0b err=%h, expected ready=1 resp=0 err=%h",
                     pat, HREADY, HRESP, ErrCount, exp_cnt);
        end
        $display("test_bad_decode sel=%h done", pat);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_wait_state();
        @(negedge HCLK);
        HTRANS    = HTRANS_NONSEQ;
        HSELVec   = 8'h08;
        HREADYVec = 8'hF7;
        @(negedge HCLK);
        HSELVec   = 8'h02;   // next transfer held on the bus during the wait
        for (int w = 0; w < 3; w++) begin
            if (w > 0) @(negedge HCLK);
            #1;
            vectors++;
            if ({HREADY, HSELDVec} !== {1'b0, 8'h08}) begin
                miscompares++;
                $display("FAIL wait_state cycle %0d: got ready=%0b seld=%h, expected ready=0 seld=08",
                         w, HREADY, HSELDVec);
            end
        end
        @(negedge HCLK);
        HREADYVec = 8'hFF;
        #1;
        vectors++;
        if ({HREADY, HRESP, HSELDVec, HREADDATA} !== {1'b1, 1'b0, 8'h08, S3_WORD}) begin
            miscompares++;
            $display("FAIL wait_release: got ready=%0b resp=%0b seld=%h data=%h, expected ready=1 resp=0 seld=08 data=%h",
                     HREADY, HRESP, HSELDVec, HREADDATA, S3_WORD);
        end
        @(negedge HCLK);
        HTRANS  = HTRANS_IDLE;
        HSELVec = 8'h00;
        #1;
        vectors++;
        if ({HREADY, HSELDVec, HREADDATA} !== {1'b1, 8'h02, S1_WORD}) begin
            miscompares++;
            $display("FAIL held_transfer_accept: got ready=%0b seld=%h data=%h, expected ready=1 seld=02 data=%h",
                     HREADY, HSELDVec, HREADDATA, S1_WORD);
        end
        @(negedge HCLK);
        $display("test_wait_state done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_slave_error();
        @(negedge HCLK);
        HTRANS   = HTRANS_NONSEQ;
        HSELVec  = 8'h04;
        HRESPVec = 8'h04;
        @(negedge HCLK);
        HTRANS  = HTRANS_IDLE;
        HSELVec = 8'h00;
        #1;
        vectors++;
        if ({HREADY, HRESP, HREADDATA, ErrCount} !== {1'b1, 1'b1, S2_WORD, 16'h0002}) begin
            miscompares++;
            $display("FAIL slave_error_pass: got ready=%0b resp=%0b data=%h err=%h, expected ready=1 resp=1 data=%h err=0002",
                     HREADY, HRESP, HREADDATA, ErrCount, S2_WORD);
        end
        @(negedge HCLK);
        HRESPVec = 8'h00;
        $display("test_slave_error done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [1:0] exp_rr [4];
        exp_rr[0] = 2'b01;   // ERR1
        exp_rr[1] = 2'b11;   // ERR2, next bad decode sampled here
        exp_rr[2] = 2'b01;   // ERR1
        exp_rr[3] = 2'b11;   // ERR2
        @(negedge HCLK);
        force dut.err_count_reg = 16'hFFFE;
        #1;
        release dut.err_count_reg;
        #1;
        vectors++;
        if (ErrCount !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL preload: got err=%h, expected err=fffe", ErrCount);
        end
        HTRANS  = HTRANS_NONSEQ;
        HSELVec = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            if (k == 2) begin
                HTRANS = HTRANS_IDLE;
            end
            #1;
            vectors++;
            if ({HREADY, HRESP, ErrCount} !== {exp_rr[k], 16'hFFFF}) begin
                miscompares++;
                $display("FAIL back_to_back step %0d: got ready=%0b resp=%0b err=%h, expected ready=%0b resp=%0b err=ffff",
                         k, HREADY, HRESP, ErrCount, exp_rr[k][1], exp_rr[k][0]);
            end
        end
        @(negedge HCLK); #1;
        vectors++;
        if ({HREADY, HRESP, ErrCount} !== {1'b1, 1'b0, 16'hFFFF}) begin
            miscompares++;
            $display("FAIL back_to_back_idle: got ready=%0b resp=%0b err=%h, expected ready=1 resp=0 err=ffff",
                     HREADY, HRESP, ErrCount);
        end
        $display("test_back_to_back done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_error();
        @(negedge HCLK);
        HTRANS  = HTRANS_NONSEQ;
        HSELVec = 8'h00;
        @(negedge HCLK);
        HTRANS  = HTRANS_IDLE;
        #1;
        vectors++;
        if ({HREADY, HRESP} !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_error_setup: got ready=%0b resp=%0b, expected ready=0 resp=1", HREADY, HRESP);
        end
        #1;
        HRESETn = 1'b0;
        #1;
        vectors++;
        if ({HREADY, HRESP, ErrCount, HSELDVec} !== {1'b1, 1'b0, 16'h0, 8'h00}) begin
            miscompares++;
            $display("FAIL async_reset: got ready=%0b resp=%0b err=%h seld=%h, expected ready=1 resp=0 err=0000 seld=00",
                     HREADY, HRESP, ErrCount, HSELDVec);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK); #1;
        vectors++;
        if ({HREADY, HRESP, ErrCount} !== {1'b1, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL no_err2_after_reset: got ready=%0b resp=%0b err=%h, expected ready=1 resp=0 err=0000",
                     HREADY, HRESP, ErrCount);
        end
        $display("test_reset_mid_error done");
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_rom_read();
        test_bad_decode(8'h00, 16'h0001);
        test_bad_decode(8'h05, 16'h0002);
        test_wait_state();
        test_slave_error();
        test_back_to_back();
        test_reset_mid_error();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ahb_resp_mux
